// File: rtl/csr_pkg.sv
// Shared constants and state types for the CSR APB controller.
// Address map, default widths and the two FSM state encodings.
package csr_pkg;

    localparam int APB_BUS_SIZE_DEF   = 32;
    localparam int ADDR_SIZE_DEF      = 8;
    localparam int FIFO_OUT_WIDTH_DEF = 25;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DATA0  = 8'h04;
    localparam logic [7:0] ADDR_DATA1  = 8'h08;
    localparam logic [7:0] ADDR_RESULT = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_RD_POP  = 2'd1,
        A_RD_DATA = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_PUSH = 2'd1,
        P_CLR  = 2'd2
    } push_state_t;

endpackage

// File: rtl/csr_apb_if.sv
// APB completer-side bus bundle for csr_apb_ctrl.
interface csr_apb_if #(
    parameter int ADDR_SIZE    = csr_pkg::ADDR_SIZE_DEF,
    parameter int APB_BUS_SIZE = csr_pkg::APB_BUS_SIZE_DEF
) ();
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_SIZE-1:0]    paddr;
    logic [APB_BUS_SIZE-1:0] prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/csr_start_seq.sv
// Start-bit push sequencer: one FIFO_IN push per CTRL start, then waits for start to clear.
//   state  | meaning
//   P_IDLE | waiting for start_bit with room in FIFO_IN
//   P_PUSH | w_en_in asserted for this single cycle
//   P_CLR  | push done, waiting for start_bit to drop
module csr_start_seq
    import csr_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_bit,
    input  logic full_out,
    output logic w_en_in,
    output logic busy
);

    push_state_t state, state_next;
    logic        w_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= P_IDLE;
            w_en_q <= 1'b0;
        end else begin
            state  <= state_next;
            w_en_q <= (state_next == P_PUSH);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            P_IDLE:  if (start_bit && !full_out) state_next = P_PUSH;
            P_PUSH:  state_next = P_CLR;
            P_CLR:   if (!start_bit) state_next = P_IDLE;
            default: state_next = P_IDLE;
        endcase
    end

    always_comb begin
        w_en_in = w_en_q;
        busy    = (state != P_IDLE) || start_bit;
    end

endmodule

// File: rtl/csr_apb_ctrl.sv
// CSR block behind APB: address decode, register strobes, RESULT pop/read sequencing.
// Define CSR_PSLVERR_EN to report decode/access errors on pslverr (tied low otherwise).
//   state     | meaning
//   A_IDLE    | accepting accesses; zero-wait except a non-empty RESULT read
//   A_RD_POP  | FIFO_OUT head captured into RESULT, read data returned
//   A_RD_DATA | one recovery cycle before the next access
module csr_apb_ctrl
    import csr_pkg::*;
#(
    parameter int APB_BUS_SIZE   = APB_BUS_SIZE_DEF,
    parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
    parameter int FIFO_OUT_WIDTH = FIFO_OUT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    csr_apb_if.slave                  apb,
    output logic                      en_ctrl,
    output logic                      en_data0,
    output logic                      en_data1,
    output logic                      w_en_in,
    input  logic                      full_out,
    input  logic                      start_bit,
    output logic                      r_en_out,
    output logic                      fifo_out_pop,
    input  logic                      fifo_out_empty,
    input  logic [FIFO_OUT_WIDTH-1:0] final_result,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status
);

    apb_state_t a_state, a_next;
    logic       busy;
    logic       access;
    logic       is_ctrl, is_d0, is_d1, is_res, is_stat;
    logic       err;
    logic       res_rd_ok;

    csr_start_seq u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_bit(start_bit),
        .full_out (full_out),
        .w_en_in  (w_en_in),
        .busy     (busy)
    );

    // Gated by rst_n so nothing combinational leaks out while reset is held.
    assign access  = apb.psel & apb.penable & rst_n;
    assign is_ctrl = (apb.paddr == ADDR_SIZE'(ADDR_CTRL));
    assign is_d0   = (apb.paddr == ADDR_SIZE'(ADDR_DATA0));
    assign is_d1   = (apb.paddr == ADDR_SIZE'(ADDR_DATA1));
    assign is_res  = (apb.paddr == ADDR_SIZE'(ADDR_RESULT));
    assign is_stat = (apb.paddr == ADDR_SIZE'(ADDR_STATUS));

    assign res_rd_ok = !apb.pwrite && is_res && !fifo_out_empty;

    always_comb begin
        err = 1'b0;
        if (!(is_ctrl || is_d0 || is_d1 || is_res || is_stat))  err = 1'b1;
        else if (apb.pwrite && (is_res || is_stat))             err = 1'b1;
        else if (!apb.pwrite && (is_d0 || is_d1))               err = 1'b1;
        else if (apb.pwrite && is_ctrl && busy)                 err = 1'b1;
        else if (!apb.pwrite && is_res && fifo_out_empty)       err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_state <= A_IDLE;
        else        a_state <= a_next;
    end

    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE:    if (access && res_rd_ok) a_next = A_RD_POP;
            A_RD_POP:  a_next = A_RD_DATA;
            A_RD_DATA: a_next = A_IDLE;
            default:   a_next = A_IDLE;
        endcase
    end

    always_comb begin
        apb.pready   = 1'b0;
        apb.pslverr  = 1'b0;
        apb.prdata   = '0;
        en_ctrl      = 1'b0;
        en_data0     = 1'b0;
        en_data1     = 1'b0;
        r_en_out     = 1'b0;
        fifo_out_pop = 1'b0;
        case (a_state)
            A_IDLE: begin
                if (access) begin
                    if (res_rd_ok) begin
                        r_en_out     = 1'b1;
                        fifo_out_pop = 1'b1;
                    end else begin
                        apb.pready = 1'b1;
`ifdef CSR_PSLVERR_EN
                        apb.pslverr = err;
`else
                        apb.pslverr = 1'b0;
`endif
                        if (!err) begin
                            if (apb.pwrite) begin
                                en_ctrl  = is_ctrl;
                                en_data0 = is_d0;
                                en_data1 = is_d1;
                            end else if (is_ctrl) begin
                                apb.prdata[0] = start_bit;
                            end else if (is_stat) begin
                                apb.prdata[FIFO_OUT_WIDTH-1:0] = fifo_out_status;
                            end
                        end
                    end
                end
            end
            A_RD_POP: begin
                r_en_out   = 1'b1;
                apb.pready = 1'b1;
                apb.prdata[FIFO_OUT_WIDTH-1:0] = final_result;
            end
            default: ;
        endcase
    end

endmodule
